// File: rtl/jkx_pkg.sv
// jkx_pkg: shared types and helpers for the JK excitation driver.
//   jkx_state_e    : driver FSM states (IDLE, DRIVE, CHECK)
//   jk_t           : {j,k} excitation pair
//   jkx_excite_fn  : excitation table, (current Q, target Q, don't-care value) -> {J,K}
//   JKX_LATENCY    : edges from accept to the chk_ok/chk_err pulse
package jkx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jkx_state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  localparam int JKX_LATENCY = 3;

  // Classic JK excitation table. The input that does not affect the outcome
  // is driven with dc: 0 gives hold-style pairs, 1 gives toggle-style pairs.
  function automatic jk_t jkx_excite_fn(input logic cur, input logic tgt, input logic dc);
    jk_t r;
    r = '{j: 1'b0, k: 1'b0};
    case ({cur, tgt})
      2'b00:   r = '{j: 1'b0, k: dc};
      2'b01:   r = '{j: 1'b1, k: dc};
      2'b10:   r = '{j: dc,   k: 1'b1};
      2'b11:   r = '{j: dc,   k: 1'b0};
      default: r = '{j: 1'b0, k: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jkx_excite.sv
// jkx_excite: purely combinational JK excitation table.
// Parameters:
//   DC_VAL - value placed on the don't-care excitation input
// Ports:
//   cur_q (in)  current FF state
//   tgt   (in)  desired FF state after the next capturing edge
//   j, k  (out) excitation that moves cur_q to tgt
module jkx_excite
  import jkx_pkg::*;
#(
  parameter logic DC_VAL = 1'b0
) (
  input  logic cur_q,
  input  logic tgt,
  output logic j,
  output logic k
);

  jk_t jk;

  assign jk = jkx_excite_fn(cur_q, tgt, DC_VAL);
  assign j  = jk.j;
  assign k  = jk.k;

endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: closed-loop stimulus/checker for an external JK FF.
// Accepts target next-state bits over valid/ready, drives the matching J/K
// for exactly one capturing edge, then verifies Q (and QN == ~Q) and reports.
//
// Parameters:
//   DC_VAL - value driven on the don't-care excitation input
//   CNT_W  - width of the saturating error counter
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   tgt_valid/tgt_bit   target offer; tgt_ready high only in IDLE
//   J, K                registered excitation to the FF
//   Q, QN               FF outputs, sampled synchronously
//   err_clr             synchronous clear of err_cnt (and halt flag)
//   chk_ok / chk_err    one-cycle result pulses
//   err_cnt             saturating failure count
// Optional feature macro: JKX_ERR_HALT_EN
//   When defined, the first failure sets a sticky halt that blocks new
//   targets until err_clr (released the cycle after) or RST.
module jk_excitation_driver
  import jkx_pkg::*;
#(
  parameter logic DC_VAL = 1'b0,
  parameter int   CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             J,
  output logic             K,
  input  logic             Q,
  input  logic             QN,
  input  logic             err_clr,
  output logic             chk_ok,
  output logic             chk_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  jkx_state_e       state_q, state_d;
  logic             j_q, j_d, k_q, k_d;
  logic             exp_q, exp_d;
  logic             ok_q, ok_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted;
  logic             accept;
  logic             fail_now;
  logic             ex_j, ex_k;

  jkx_excite #(.DC_VAL(DC_VAL)) u_excite (
    .cur_q (Q),
    .tgt   (tgt_bit),
    .j     (ex_j),
    .k     (ex_k)
  );

`ifdef JKX_ERR_HALT_EN
  logic halt_q, halt_d;
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  // RST is folded in so ready is low for the whole reset window.
  assign tgt_ready = (state_q == IDLE) && !halted && !RST;
  assign accept    = tgt_valid && tgt_ready;

  always_comb begin
    state_d  = state_q;
    j_d      = 1'b0;      // J/K rest at hold (0,0) except for the drive cycle
    k_d      = 1'b0;
    exp_d    = exp_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    fail_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          j_d     = ex_j;
          k_d     = ex_k;
          exp_d   = tgt_bit;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // FF captures J/K at the closing edge of this cycle
        state_d = CHECK;
      end
      CHECK: begin
        // A complement violation fails even if Q itself is right
        fail_now = (Q != exp_q) || (QN == Q);
        ok_d     = !fail_now;
        err_d    = fail_now;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats a coincident increment; saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if (fail_now && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
  end

`ifdef JKX_ERR_HALT_EN
  always_comb begin
    halt_d = halt_q;
    if (err_clr)
      halt_d = 1'b0;
    else if (fail_now)
      halt_d = 1'b1;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      exp_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef JKX_ERR_HALT_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef JKX_ERR_HALT_EN
      halt_q  <= halt_d;
`endif
    end
  end

  assign J       = j_q;
  assign K       = k_q;
  assign chk_ok  = ok_q;
  assign chk_err = err_q;
  assign err_cnt = cnt_q;

endmodule
